rssb_result_collector: RTL and testbench

Single-clock capture block on the CPU result side of the RSSB core. It samples the narrow `result`/`flag` stream the CPU drives back toward memory on every enabled step, packs the result bits LSB-first into `WW`-bit words, and queues them in a small FIFO with a valid/ready output port. It also counts borrows and flags FIFO overflow, so a host or test harness can read the CPU's output without touching the three-phase core clocks.

---
 rtl/rssb_result_collector_if.sv | 11 +
 rtl/rssb_result_collector.sv | 78 +++++++
 tb/tb_rssb_result_collector.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rssb_result_collector_if.sv
// Output word stream of the RSSB result collector: head-of-FIFO word with valid/ready.
interface rssb_result_collector_if #(
  parameter int WW = 8
);
  logic [WW-1:0] word_out;
  logic          word_valid;
  logic          word_ready;

  modport master (output word_out, output word_valid, input word_ready);
  modport slave  (input word_out, input word_valid, output word_ready);
endinterface

// File: rtl/rssb_result_collector.sv
// Captures the CPU result/flag stream, packs result chunks LSB-first into words,
// queues them in a small FIFO, counts borrows and flags dropped words.
module rssb_result_collector #(
  parameter int BW = 1,
  parameter int WW = 8,
  parameter int FD = 4,
  parameter int CW = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic                   flag,
  input  logic [BW-1:0]          result,
  input  logic                   flush,
  rssb_result_collector_if.master words,
  output logic [$clog2(FD):0]    level,
  output logic                   overflow,
  output logic [CW-1:0]          borrow_cnt
);

  localparam int NCH = WW / BW;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int AW  = $clog2(FD);

  logic [WW-1:0] acc, acc_cap;
  logic [IW-1:0] bidx, bidx_cap;
  logic          push, pop, wr, full, empty;
  logic [AW:0]   wptr, rptr;
  logic [WW-1:0] mem [FD];

  // The chunk captured this cycle is merged before deciding whether to push,
  // so a capture that completes the word together with flush pushes only once.
  always_comb begin
    acc_cap  = acc;
    bidx_cap = bidx;
    if (ena) begin
      acc_cap[bidx*BW +: BW] = result;
      bidx_cap               = bidx + 1'b1;
    end
    push = (ena && (bidx == IW'(NCH - 1))) || (flush && (ena || (bidx != '0)));
  end

  assign level            = wptr - rptr;
  assign empty            = (wptr == rptr);
  assign full             = (level == (AW + 1)'(FD));
  assign words.word_valid = !empty;
  assign words.word_out   = empty ? '0 : mem[rptr[AW-1:0]];
  assign pop              = !empty && words.word_ready;
  assign wr               = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      bidx       <= '0;
      wptr       <= '0;
      rptr       <= '0;
      overflow   <= 1'b0;
      borrow_cnt <= '0;
    end else begin
      acc  <= push ? '0 : acc_cap;
      bidx <= push ? '0 : bidx_cap;
      if (pop)
        rptr <= rptr + 1'b1;
      if (wr)
        wptr <= wptr + 1'b1;
      if (push && full && !pop)
        overflow <= 1'b1;
      if (ena && flag && (borrow_cnt != '1))
        borrow_cnt <= borrow_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr && !rst)
      mem[wptr[AW-1:0]] <= acc_cap;
  end

endmodule

// File: tb/tb_rssb_result_collector.sv
// Self-checking bench for rssb_result_collector (BW=1, WW=8, FD=4, CW=8) with a
// queue-based reference model updated alongside every clock cycle.
module tb_rssb_result_collector;

  localparam int FD = 4;

  logic       clk = 1'b0;
  logic       rst, ena, flag, flush;
  logic [0:0] result;
  logic [2:0] level;
  logic       overflow;
  logic [7:0] borrow_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: pending bits of the partial word, queued words, flags.
  bit         mbits[$];
  logic [7:0] mq[$];
  bit         movf;
  int         mcnt;

  rssb_result_collector_if #(.WW(8)) wif ();

  rssb_result_collector #(.BW(1), .WW(8), .FD(4), .CW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .flag      (flag),
    .result    (result),
    .flush     (flush),
    .words     (wif),
    .level     (level),
    .overflow  (overflow),
    .borrow_cnt(borrow_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // Drive one cycle of inputs, clock it, and advance the model the same way.
  task automatic step(input bit e, input bit f, input bit r, input bit fl,
                      input bit rdy, input bit rs);
    bit         popd;
    bit         pushd;
    logic [7:0] w;
    ena = e; flag = f; result = r; flush = fl; wif.word_ready = rdy; rst = rs;
    @(posedge clk);
    if (rs) begin
      mbits.delete();
      mq.delete();
      movf = 0;
      mcnt = 0;
    end else begin
      popd  = (mq.size() > 0) && rdy;
      pushd = 0;
      w     = '0;
      if (e) begin
        mbits.push_back(r);
        if (f && mcnt < 255) mcnt++;
      end
      if (mbits.size() == 8 || (fl && mbits.size() > 0)) begin
        foreach (mbits[i]) w[i] = mbits[i];
        mbits.delete();
        pushd = 1;
      end
      if (popd) void'(mq.pop_front());
      if (pushd) begin
        if (mq.size() < FD) mq.push_back(w);
        else movf = 1;
      end
    end
    #1;
  endtask

  task automatic push_word(input logic [7:0] w, input bit rdy_last);
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b0, w[i], 1'b0, (i == 7) ? rdy_last : 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      checks++;
      if (wif.word_valid !== 1'b0 || wif.word_out !== 8'h00) begin
        errors++;
        $display("FAIL reset_word: valid=%b out=%h expected valid=0 out=00", wif.word_valid, wif.word_out);
      end
      checks++;
      if (level !== 3'd0 || overflow !== 1'b0 || borrow_cnt !== 8'd0) begin
        errors++;
        $display("FAIL reset_state: level=%0d ovf=%b cnt=%0d expected 0 0 0", level, overflow, borrow_cnt);
      end
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (level !== 3'd0 || wif.word_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_push: level=%0d valid=%b expected 0 0", level, wif.word_valid);
    end
  endtask

  task automatic test_single_word();
    logic [7:0] bits;
    bits = 8'b0100_1101;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, bits[i], 1'b0, 1'b0, 1'b0);
      if (i == 6) begin
        checks++;
        if (wif.word_valid !== 1'b0) begin
          errors++;
          $display("FAIL single_early_valid: valid=%b expected 0", wif.word_valid);
        end
      end
    end
    checks++;
    if (wif.word_valid !== 1'b1 || wif.word_out !== 8'h4D || level !== 3'd1) begin
      errors++;
      $display("FAIL single_word: valid=%b out=%h level=%0d expected 1 4d 1", wif.word_valid, wif.word_out, level);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (wif.word_out !== 8'h4D || wif.word_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_hold: valid=%b out=%h expected 1 4d", wif.word_valid, wif.word_out);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (wif.word_valid !== 1'b0 || level !== 3'd0) begin
      errors++;
      $display("FAIL single_pop: valid=%b level=%0d expected 0 0", wif.word_valid, level);
    end
  endtask

  task automatic test_flush();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (wif.word_out !== 8'h03 || level !== 3'd1) begin
      errors++;
      $display("FAIL flush_capture: out=%h level=%0d expected 03 1", wif.word_out, level);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (level !== 3'd1) begin
      errors++;
      $display("FAIL flush_lone: level=%0d expected 1", level);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    // Eighth capture together with flush: exactly one word.
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b0, 1'b1, (i == 7), 1'b0, 1'b0);
    checks++;
    if (level !== 3'd1 || wif.word_out !== 8'hFF) begin
      errors++;
      $display("FAIL flush_complete: level=%0d out=%h expected 1 ff", level, wif.word_out);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (level !== 3'd0 || wif.word_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_single_push: level=%0d valid=%b expected 0 0", level, wif.word_valid);
    end
  endtask

  task automatic test_overflow();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 4; k++) push_word(8'(k), 1'b0);
    checks++;
    if (level !== 3'd4 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_full: level=%0d ovf=%b expected 4 0", level, overflow);
    end
    push_word(8'h05, 1'b0);
    checks++;
    if (level !== 3'd4 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: level=%0d ovf=%b expected 4 1", level, overflow);
    end
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (wif.word_valid !== 1'b1 || wif.word_out !== 8'(k)) begin
        errors++;
        $display("FAIL ovf_drain: valid=%b out=%h expected 1 %h", wif.word_valid, wif.word_out, 8'(k));
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    checks++;
    if (wif.word_valid !== 1'b0 || level !== 3'd0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_after_drain: valid=%b level=%0d ovf=%b expected 0 0 1", wif.word_valid, level, overflow);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_reset: ovf=%b expected 0", overflow);
    end
  endtask

  task automatic test_full_push_pop();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 4; k++) push_word(8'(k), 1'b0);
    push_word(8'h05, 1'b1);
    checks++;
    if (level !== 3'd4 || overflow !== 1'b0 || wif.word_out !== 8'h02) begin
      errors++;
      $display("FAIL full_pushpop: level=%0d ovf=%b out=%h expected 4 0 02", level, overflow, wif.word_out);
    end
    for (int k = 2; k <= 5; k++) begin
      checks++;
      if (wif.word_out !== 8'(k)) begin
        errors++;
        $display("FAIL full_pushpop_drain: out=%h expected %h", wif.word_out, 8'(k));
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    checks++;
    if (level !== 3'd0) begin
      errors++;
      $display("FAIL full_pushpop_empty: level=%0d expected 0", level);
    end
  endtask

  task automatic test_borrow_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 300; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      if (i == 254 || i == 255 || i == 300) begin
        checks++;
        if (borrow_cnt !== 8'((i < 255) ? i : 255)) begin
          errors++;
          $display("FAIL borrow_sat: cnt=%0d expected %0d after %0d captures", borrow_cnt, (i < 255) ? i : 255, i);
        end
      end
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (borrow_cnt !== 8'd0 || level !== 3'd0) begin
      errors++;
      $display("FAIL midword_reset: cnt=%0d level=%0d expected 0 0", borrow_cnt, level);
    end
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (level !== 3'd1 || wif.word_out !== 8'hFF || borrow_cnt !== 8'd8) begin
      errors++;
      $display("FAIL midword_word: level=%0d out=%h cnt=%0d expected 1 ff 8", level, wif.word_out, borrow_cnt);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_out;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(99) < 70, $urandom_range(1), $urandom_range(1),
           $urandom_range(99) < 8, $urandom_range(99) < 35, $urandom_range(499) == 0);
      exp_out = (mq.size() > 0) ? mq[0] : 8'h00;
      checks++;
      if (wif.word_valid !== (mq.size() > 0) || wif.word_out !== exp_out) begin
        errors++;
        $display("FAIL rand_word cycle %0d: valid=%b out=%h expected %b %h", n, wif.word_valid, wif.word_out, mq.size() > 0, exp_out);
      end
      checks++;
      if (level !== 3'(mq.size()) || overflow !== movf || borrow_cnt !== 8'(mcnt)) begin
        errors++;
        $display("FAIL rand_state cycle %0d: level=%0d ovf=%b cnt=%0d expected %0d %b %0d", n, level, overflow, borrow_cnt, mq.size(), movf, mcnt);
      end
    end
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; flag = 1'b0; result = 1'b0; flush = 1'b0; wif.word_ready = 1'b0;
    test_reset();
    test_single_word();
    test_flush();
    test_overflow();
    test_full_push_pop();
    test_borrow_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
